// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
//
// Sequencing controller for the 2-bit add/sub/multiply calculator. Each raw
// push-button is synchronised and debounced into a single-cycle press pulse.
// An FSM then steps the user through load A -> load B -> execute -> show.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous, active-high reset
//   btnLoadA     raw button: load operand A
//   btnLoadB     raw button: load operand B
//   btnExec      raw button: execute the selected operation
//   btnClear     raw button: abort the sequence and clear the display
//   op_in        opcode switches (00 add, 01 sub, 10 mul, 11 illegal)
//   alu_result   combinational ALU result
//   alu_status   ALU carry/borrow/overflow flag
//   loadA        one-cycle load strobe for operand register A
//   loadB        one-cycle load strobe for operand register B
//   op_out       registered opcode driving the ALU
//   result_led   captured ALU result
//   flag_led     captured ALU flag
//   err          sticky illegal-opcode indication
//   state_out    current FSM state encoding for the debug LEDs
// ---------------------------------------------------------------------------
module calc_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnLoadA,
    input  logic       btnLoadB,
    input  logic       btnExec,
    input  logic       btnClear,
    input  logic [1:0] op_in,
    input  logic [3:0] alu_result,
    input  logic       alu_status,
    output logic       loadA,
    output logic       loadB,
    output logic [1:0] op_out,
    output logic [3:0] result_led,
    output logic       flag_led,
    output logic       err,
    output logic [2:0] state_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button lanes, one bit each.
    localparam int BTN_A   = 0;
    localparam int BTN_B   = 1;
    localparam int BTN_EX  = 2;
    localparam int BTN_CLR = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_B = 3'd1,
        READY  = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Button front end: 2-flop synchroniser, debounce counter, edge detect
    // ------------------------------------------------------------------
    logic [3:0]       btn_raw;
    logic [3:0]       sync1_q, s_q;
    logic [3:0]       db_q, db_d, db_dly_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       press;

    assign btn_raw = {btnClear, btnExec, btnLoadB, btnLoadA};

    // NOTE: in a combinational block every output gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (s_q[i] != db_q[i]) begin
                // The level is only accepted after an unbroken run of
                // differing samples; any agreeing sample restarts the run.
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            s_q      <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn_raw;
            s_q      <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // One pulse per accepted rising level; releases produce nothing.
    assign press = db_q & ~db_dly_q;

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [3:0] result_q, result_d;
    logic       flag_q, flag_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        flag_d   = flag_q;
        err_d    = err_q;
        loadA    = 1'b0;
        loadB    = 1'b0;

        // Clear outranks every other button and suppresses all strobes.
        if (press[BTN_CLR]) begin
            state_d  = IDLE;
            result_d = '0;
            flag_d   = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press[BTN_A]) begin
                        loadA   = 1'b1;
                        err_d   = 1'b0;
                        state_d = WAIT_B;
                    end
                end
                WAIT_B: begin
                    loadA = press[BTN_A];
                    if (press[BTN_B]) begin
                        loadB   = 1'b1;
                        state_d = READY;
                    end
                end
                READY: begin
                    // Operand reloads win over a simultaneous execute.
                    if (press[BTN_A] || press[BTN_B]) begin
                        loadA = press[BTN_A];
                        loadB = press[BTN_B];
                    end else if (press[BTN_EX]) begin
                        if (op_in == 2'b11) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            op_d    = op_in;
                            state_d = EXEC;
                        end
                    end
                end
                EXEC: begin
                    // The ALU has seen operands and op_out for a full cycle.
                    result_d = alu_result;
                    flag_d   = alu_status;
                    state_d  = SHOW;
                end
                SHOW: begin
                    if (press[BTN_A]) begin
                        loadA   = 1'b1;
                        state_d = WAIT_B;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign op_out     = op_q;
    assign result_led = result_q;
    assign flag_led   = flag_q;
    assign err        = err_q;
    assign state_out  = state_q;

endmodule
